// File: rtl/morse_keyer.sv
// morse_keyer -- sends one Morse character per handshake as keyed tone.
//
// A character (up to five dot/dash elements, bit 0 first, 1 = dash) is taken
// on a ch_valid/ch_ready transfer together with the unit length and the tone
// duty value. The keyer then plays marks (1 unit dot, 3 units dash) separated
// by 1-unit gaps, followed by a 3-unit character gap, and pulses ch_done.
//
// Ports
//   cclk        clock, all state on the rising edge
//   rstb        asynchronous active-low reset
//   ch_valid    character offered
//   ch_ready    keyer idle, a character can be taken
//   ch_len      number of elements, 0..5 (larger values clamp to 5)
//   ch_bits     element i on bit i, 1 = dash, 0 = dot
//   unit_len    cclk cycles per Morse unit (0 behaves as 1)
//   tone_duty   duty value emitted while keyed
//   duty_cycle  duty value to the downstream PWM (0 when not keyed)
//   key_on      tone keyed
//   ch_done     one-cycle pulse on the last cycle of the trailing gap
//
// Build option
//   MORSE_WORD_GAP_EN  when defined, ch_len = 0 produces a 7-unit word gap
//                      (state WGAP); otherwise it produces a 3-unit silence.
//
// Timing note: the ch_done cycle is already state IDLE (ch_ready = 1) and is
// counted as the final cycle of the trailing gap, so a character offered back
// to back starts its first mark exactly 3 (or 7) units after the last mark.
// This is done by starting the trailing-gap counters one cycle advanced.

module morse_keyer #(
    parameter int UNIT_W = 16
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              ch_valid,
    output logic              ch_ready,
    input  logic [2:0]        ch_len,
    input  logic [4:0]        ch_bits,
    input  logic [UNIT_W-1:0] unit_len,
    input  logic [7:0]        tone_duty,
    output logic [7:0]        duty_cycle,
    output logic              key_on,
    output logic              ch_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MARK = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_CGAP = 3'd3;
`ifdef MORSE_WORD_GAP_EN
    localparam logic [2:0] S_WGAP = 3'd4;
    localparam logic [2:0] S_EMPTY = S_WGAP;
`else
    localparam logic [2:0] S_EMPTY = S_CGAP;
`endif

    localparam logic [UNIT_W-1:0] U_ONE  = {{(UNIT_W-1){1'b0}}, 1'b1};
    localparam logic [UNIT_W-1:0] U_ZERO = '0;

    logic [2:0]        state, state_nx;
    logic [2:0]        len_q;
    logic [4:0]        bits_q;
    logic [UNIT_W-1:0] unit_q;
    logic [7:0]        tone_q;
    logic [UNIT_W-1:0] ucnt, ucnt_nx;     // cycle within the current unit
    logic [2:0]        ecnt, ecnt_nx;     // unit within the current phase
    logic [2:0]        eidx, eidx_nx;     // element being sent
    logic              done_nx;

    logic              xfer;
    logic [2:0]        len_in;
    logic [UNIT_W-1:0] unit_in;
    logic [2:0]        units;             // length of the current phase in units
    logic              unit_end, phase_end;
    logic [7:0]        tone_nx;

    assign ch_ready = (state == S_IDLE);
    assign xfer     = ch_valid && ch_ready;
    assign len_in   = (ch_len > 3'd5) ? 3'd5 : ch_len;
    assign unit_in  = (unit_len == U_ZERO) ? U_ONE : unit_len;
    assign tone_nx  = xfer ? tone_duty : tone_q;

    always_comb begin
        units = 3'd1;
        case (state)
            S_MARK:  units = bits_q[eidx] ? 3'd3 : 3'd1;
            S_GAP:   units = 3'd1;
            S_CGAP:  units = 3'd3;
`ifdef MORSE_WORD_GAP_EN
            S_WGAP:  units = 3'd7;
`endif
            default: units = 3'd1;
        endcase
    end

    assign unit_end  = (ucnt == unit_q - U_ONE);
    assign phase_end = unit_end && (ecnt == units - 3'd1);

    always_comb begin
        state_nx = state;
        ucnt_nx  = ucnt;
        ecnt_nx  = ecnt;
        eidx_nx  = eidx;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    eidx_nx = 3'd0;
                    if (len_in != 3'd0) begin
                        state_nx = S_MARK;
                        ucnt_nx  = U_ZERO;
                        ecnt_nx  = 3'd0;
                    end else begin
                        // trailing gap starts one cycle advanced (see header)
                        state_nx = S_EMPTY;
                        ucnt_nx  = (unit_in == U_ONE) ? U_ZERO : U_ONE;
                        ecnt_nx  = (unit_in == U_ONE) ? 3'd1 : 3'd0;
                    end
                end
            end
            S_MARK: begin
                if (phase_end) begin
                    if (eidx + 3'd1 < len_q) begin
                        state_nx = S_GAP;
                        ucnt_nx  = U_ZERO;
                        ecnt_nx  = 3'd0;
                    end else begin
                        state_nx = S_CGAP;
                        ucnt_nx  = (unit_q == U_ONE) ? U_ZERO : U_ONE;
                        ecnt_nx  = (unit_q == U_ONE) ? 3'd1 : 3'd0;
                    end
                end else if (unit_end) begin
                    ucnt_nx = U_ZERO;
                    ecnt_nx = ecnt + 3'd1;
                end else begin
                    ucnt_nx = ucnt + U_ONE;
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    state_nx = S_MARK;
                    eidx_nx  = eidx + 3'd1;
                    ucnt_nx  = U_ZERO;
                    ecnt_nx  = 3'd0;
                end else begin
                    ucnt_nx = ucnt + U_ONE;
                end
            end
`ifdef MORSE_WORD_GAP_EN
            S_CGAP, S_WGAP: begin
`else
            S_CGAP: begin
`endif
                if (phase_end) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                    ucnt_nx  = U_ZERO;
                    ecnt_nx  = 3'd0;
                    eidx_nx  = 3'd0;
                end else if (unit_end) begin
                    ucnt_nx = U_ZERO;
                    ecnt_nx = ecnt + 3'd1;
                end else begin
                    ucnt_nx = ucnt + U_ONE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                ucnt_nx  = U_ZERO;
                ecnt_nx  = 3'd0;
                eidx_nx  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state      <= S_IDLE;
            ucnt       <= U_ZERO;
            ecnt       <= 3'd0;
            eidx       <= 3'd0;
            len_q      <= 3'd0;
            bits_q     <= 5'd0;
            unit_q     <= U_ZERO;
            tone_q     <= 8'd0;
            key_on     <= 1'b0;
            duty_cycle <= 8'd0;
            ch_done    <= 1'b0;
        end else begin
            state <= state_nx;
            ucnt  <= ucnt_nx;
            ecnt  <= ecnt_nx;
            eidx  <= eidx_nx;
            if (xfer) begin
                len_q  <= len_in;
                bits_q <= ch_bits;
                unit_q <= unit_in;
                tone_q <= tone_duty;
            end
            // outputs follow the next state so they line up with it exactly
            key_on     <= (state_nx == S_MARK);
            duty_cycle <= (state_nx == S_MARK) ? tone_nx : 8'd0;
            ch_done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: a per-cycle expectation queue built from the Morse
// timing rules is compared with the DUT every cycle, plus literal checks of
// captured waveforms for the hand-computed cases.
module tb_morse_keyer;

`ifdef MORSE_WORD_GAP_EN
    localparam int WG = 7;
`else
    localparam int WG = 3;
`endif

    logic        cclk = 1'b0;
    logic        rstb = 1'b0;
    logic        ch_valid = 1'b0;
    logic        ch_ready;
    logic [2:0]  ch_len = 3'd0;
    logic [4:0]  ch_bits = 5'd0;
    logic [15:0] unit_len = 16'd0;
    logic [7:0]  tone_duty = 8'd0;
    logic [7:0]  duty_cycle;
    logic        key_on;
    logic        ch_done;

    morse_keyer #(.UNIT_W(16)) dut (
        .cclk(cclk), .rstb(rstb), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_len(ch_len), .ch_bits(ch_bits), .unit_len(unit_len),
        .tone_duty(tone_duty), .duty_cycle(duty_cycle), .key_on(key_on),
        .ch_done(ch_done)
    );

    always #5 cclk = ~cclk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d @%0t", name, got, want, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        bit       k;
        bit [7:0] d;
        bit       dn;
        bit       rdy;
    } ent_t;

    localparam ent_t IDLE_E = '{k: 1'b0, d: 8'd0, dn: 1'b0, rdy: 1'b1};

    ent_t q[$];
    ent_t cur = IDLE_E;

    task automatic push(input bit k, input bit [7:0] d, input bit last);
        ent_t e;
        e.k = k; e.d = d; e.dn = last; e.rdy = last;
        q.push_back(e);
    endtask

    // expand one character into its cycle-by-cycle output sequence
    task automatic gen(input int l, input logic [4:0] b, input int u, input logic [7:0] d);
        int n;
        if (u == 0) u = 1;
        if (l > 5) l = 5;
        for (int i = 0; i < l; i++) begin
            n = (b[i] ? 3 : 1) * u;
            for (int j = 0; j < n; j++) push(1'b1, d, 1'b0);
            if (i < l - 1)
                for (int j = 0; j < u; j++) push(1'b0, 8'd0, 1'b0);
        end
        n = ((l == 0) ? WG : 3) * u;
        for (int j = 0; j < n; j++) push(1'b0, 8'd0, j == n - 1);
    endtask

    always @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            q.delete();
            cur = IDLE_E;
        end else begin
            if (ch_valid && cur.rdy)
                gen(int'(ch_len), ch_bits, int'(unit_len), tone_duty);
            if (q.size() > 0) cur = q.pop_front();
            else cur = IDLE_E;
        end
    end

    always @(negedge cclk) begin
        if (rstb) begin
            chk("key_on", int'(key_on), int'(cur.k));
            chk("duty_cycle", int'(duty_cycle), int'(cur.d));
            chk("ch_done", int'(ch_done), int'(cur.dn));
            chk("ch_ready", int'(ch_ready), int'(cur.rdy));
        end
    end

    // ---------------- stimulus helpers ----------------
    bit cap_k[64];
    bit cap_d[64];
    int qlen0;

    task automatic send(input logic [2:0] l, input logic [4:0] b,
                        input logic [15:0] u, input logic [7:0] d);
        int t = 0;
        @(negedge cclk);
        ch_len = l; ch_bits = b; unit_len = u; tone_duty = d; ch_valid = 1'b1;
        while (!ch_ready && t < 300) begin
            @(negedge cclk);
            t++;
        end
        if (t >= 300) chk("send_timeout", t, 0);
        @(posedge cclk);
    endtask

    // sample n cycles starting with the first cycle after the transfer edge
    task automatic capture(input int n, input bit drop);
        for (int i = 0; i < n; i++) begin
            @(negedge cclk);
            cap_k[i] = key_on;
            cap_d[i] = ch_done;
            if (i == 0) begin
                qlen0 = q.size() + 1;
                if (drop) ch_valid = 1'b0;
            end
        end
    endtask

    function automatic int ones(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(cap_k[i]);
        return c;
    endfunction

    function automatic int done_idx(input int n);
        for (int i = 0; i < n; i++) if (cap_d[i]) return i;
        return -1;
    endfunction

    function automatic int rises(input int n);
        int c = 0;
        bit p = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (cap_k[i] && !p) c++;
            p = cap_k[i];
        end
        return c;
    endfunction

    function automatic int first_run(input int n);
        int c = 0;
        for (int i = 0; i < n && cap_k[i]; i++) c++;
        return c;
    endfunction

    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || !cur.rdy) && t < 500) begin
            @(negedge cclk);
            t++;
        end
        if (t >= 500) chk("idle_timeout", t, 0);
        @(negedge cclk);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        #3;
        chk("rst_key_on", int'(key_on), 0);
        chk("rst_duty", int'(duty_cycle), 0);
        chk("rst_done", int'(ch_done), 0);
        chk("rst_ready", int'(ch_ready), 1);
        #10 rstb = 1'b1;
        repeat (2) @(negedge cclk);

        // "A": dot dash, unit 4
        send(3'd2, 5'b00010, 16'd4, 8'd128);
        capture(33, 1'b1);
        chk("A_model_len", qlen0, 32);
        chk("A_first_run", first_run(33), 4);
        chk("A_ones", ones(33), 16);
        chk("A_low_gap", int'(cap_k[7]), 0);
        chk("A_dash_start", int'(cap_k[8]), 1);
        chk("A_done_idx", done_idx(33), 31);
        wait_idle();

        // "E" with unit 0, then unit 1: identical timing
        send(3'd1, 5'b00000, 16'd0, 8'd9);
        capture(5, 1'b1);
        chk("E0_model_len", qlen0, 4);
        chk("E0_ones", ones(5), 1);
        chk("E0_done_idx", done_idx(5), 3);
        wait_idle();
        send(3'd1, 5'b00000, 16'd1, 8'd9);
        capture(5, 1'b1);
        chk("E1_ones", ones(5), 1);
        chk("E1_done_idx", done_idx(5), 3);
        wait_idle();

        // length 7 clamps to 5 dashes, unit 2
        send(3'd7, 5'b11111, 16'd2, 8'd200);
        capture(45, 1'b1);
        chk("C5_model_len", qlen0, 44);
        chk("C5_ones", ones(45), 30);
        chk("C5_dashes", rises(45), 5);
        chk("C5_first_run", first_run(45), 6);
        chk("C5_done_idx", done_idx(45), 43);
        wait_idle();

        // "T","T" back to back with ch_valid held
        send(3'd1, 5'b00001, 16'd3, 8'd60);
        capture(27, 1'b0);
        chk("TT_first_run", first_run(27), 9);
        chk("TT_ones", ones(27), 18);
        chk("TT_gap_end", int'(cap_k[17]), 0);
        chk("TT_second", int'(cap_k[18]), 1);
        chk("TT_done_idx", done_idx(27), 17);
        ch_valid = 1'b0;
        wait_idle();

        // offer changing fields while busy: must wait for ch_ready
        send(3'd2, 5'b00001, 16'd2, 8'd33);
        @(negedge cclk) ch_valid = 1'b0;
        repeat (3) @(negedge cclk);
        send(3'd1, 5'b00001, 16'd1, 8'd50);
        @(negedge cclk) ch_valid = 1'b0;
        wait_idle();

        // empty character
        send(3'd0, 5'b10101, 16'd5, 8'd77);
        capture(WG * 5 + 1, 1'b1);
        chk("SP_model_len", qlen0, WG * 5);
        chk("SP_ones", ones(WG * 5 + 1), 0);
        chk("SP_done_idx", done_idx(WG * 5 + 1), WG * 5 - 1);
        wait_idle();

        // asynchronous reset in the middle of a dash
        send(3'd1, 5'b00001, 16'd4, 8'd77);
        @(negedge cclk) ch_valid = 1'b0;
        repeat (4) @(negedge cclk);
        chk("RS_keyed_before", int'(key_on), 1);
        @(posedge cclk);
        #2 rstb = 1'b0;
        #1;
        chk("RS_key_off", int'(key_on), 0);
        chk("RS_duty_off", int'(duty_cycle), 0);
        chk("RS_no_done", int'(ch_done), 0);
        #1 rstb = 1'b1;
        repeat (20) @(negedge cclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_keyer.md
MORSE_KEYER -- requirements
Module: morse_keyer

Interface
REQ-001 SHALL have parameter UNIT_W, default 16, giving the width of the unit-length counter in bits.
REQ-002 SHALL have port cclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstb, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port ch_valid, input, 1 bit: a character is offered.
REQ-005 SHALL have port ch_ready, output, 1 bit: the keyer can accept a character.
REQ-006 SHALL have port ch_len, input, 3 bits: number of elements in the character, 0..5.
REQ-007 SHALL have port ch_bits, input, 5 bits: element i is carried on bit i, with bit 0 sent first; 1 = dash, 0 = dot.
REQ-008 SHALL have port unit_len, input, UNIT_W bits: cclk cycles per Morse unit.
REQ-009 SHALL have port tone_duty, input, 8 bits: duty value to emit while keyed.
REQ-010 SHALL have port duty_cycle, output, 8 bits: feeds the downstream PWM duty_cycle input.
REQ-011 SHALL have port key_on, output, 1 bit: the tone is currently keyed.
REQ-012 SHALL have port ch_done, output, 1 bit: one-cycle pulse when a character, including its trailing gap, is complete.

Function
REQ-013 SHALL drive ch_ready high only in state IDLE; a transfer occurs on a rising edge with ch_valid=1 and ch_ready=1.
REQ-014 SHALL latch ch_len, ch_bits, unit_len and tone_duty on transfer, ignoring further input changes until the next transfer.
REQ-015 SHALL clamp a latched ch_len greater than 5 to 5.
REQ-016 SHALL treat a latched unit_len of 0 as 1.
REQ-017 SHALL implement the FSM states IDLE, MARK, GAP and CGAP.
REQ-018 SHALL go from IDLE to MARK on a transfer with ch_len != 0; with ch_len = 0, see REQ-027 and REQ-028.
REQ-019 SHALL hold MARK for 1 unit for a dot and 3 units for a dash; key_on=1 and duty_cycle equal to the latched tone_duty throughout MARK.
REQ-020 SHALL, at the end of MARK, go to GAP (1 unit) if elements remain, otherwise to CGAP (3 units); key_on=0 and duty_cycle=0 in GAP and CGAP.
REQ-021 SHALL, at the end of GAP, return to MARK for the next element.
REQ-022 SHALL, at the end of CGAP, pulse ch_done for exactly 1 cycle and enter IDLE, with ch_ready=1 in that same cycle.
REQ-023 SHALL register key_on and duty_cycle, so that for a transfer at edge N both outputs are valid from edge N, and a mark of k units spans exactly k*unit_len cycles with no gap cycles between states.
REQ-024 SHALL implement the unit counter as an UNIT_W-bit counter that counts 0..unit_len-1 and wraps, and an element/gap counter that counts units; neither counter may overflow for unit_len up to 2^UNIT_W-1.
REQ-025 SHALL not alter the current character when ch_valid is asserted while busy; the offer is held until ch_ready.

Reset
REQ-026 SHALL, on rstb=0 and regardless of clock or state (mid-character included), immediately force: state IDLE, all counters 0, key_on=0, duty_cycle=0, ch_done=0, ch_ready=1 after release; no partial character resumes after reset.

Configuration
REQ-027 SHALL, when MORSE_WORD_GAP_EN is defined, treat ch_len=0 as a word space: go from IDLE directly to a WGAP state of 7 units with key_on=0, then pulse ch_done and enter IDLE.
REQ-028 SHALL, when MORSE_WORD_GAP_EN is not defined, treat ch_len=0 as silence: go to CGAP (3 units, key_on=0), then pulse ch_done; the WGAP state is absent.

Verification
REQ-029 SHALL cover: unit_len=4, tone_duty=128, "A" (ch_len=2, ch_bits=00010) -> key_on 4 cycles high, 4 low, 12 high, 12 low, then one ch_done pulse; duty_cycle=128 only while key_on.
REQ-030 SHALL cover: unit_len=0, "E" (ch_len=1, ch_bits=0) -> key_on 1 cycle high, 3 low, then ch_done; same timing as unit_len=1.
REQ-031 SHALL cover: ch_len=7, ch_bits=11111, unit_len=2 -> exactly 5 dashes of 6 cycles each, 2-cycle gaps, then a 6-cycle CGAP.
REQ-032 SHALL cover: back-to-back "T","T" with ch_valid held high, unit_len=3 -> second transfer on the ch_done cycle; key_on pattern 9 high, 9 low, 9 high.
REQ-033 SHALL cover: rstb pulsed low mid-dash, asynchronously between clock edges -> key_on and duty_cycle go to 0 without waiting for a clock edge; ch_ready=1 on the first edge after release; no ch_done.
REQ-034 SHALL cover: ch_len=0, unit_len=5 -> with MORSE_WORD_GAP_EN, 35 silent cycles then ch_done; without it, 15 silent cycles then ch_done.
